// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder (WIDTH = 4*NIBBLES) built around a single 4-bit
// carry-lookahead slice, one nibble per clock with the carry registered between nibbles.
// Operands arrive on a valid/ready handshake. The result leaves on a valid/ready handshake
// NIBBLES clocks after acceptance.
// Optional build macro: NIBBLE_SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 c_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 c_out,
  output logic                 busy
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int unsigned Width = 4 * NIBBLES;
  localparam int unsigned IdxW  = $clog2(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e            state_q, state_d;
  logic [Width-1:0]  a_q, a_d;
  logic [Width-1:0]  b_q, b_d;
  logic [Width-1:0]  sum_q, sum_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic              accept;
  logic              last_nibble;
  logic [3:0]        slice_a, slice_b, slice_sum;
  logic [3:0]        slice_g, slice_p;
  logic [4:0]        slice_c;

  assign accept      = in_valid && (state_q == StIdle);
  assign last_nibble = (idx_q == LastIdx);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one ADD cycle per nibble, then hold in DONE until the consumer takes it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StAdd;
      StAdd:   if (last_nibble) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    sum       = sum_q;
    c_out     = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ovf       = ovf_q;
`endif
  end

  // Select the current nibble of each latched operand.
  always_comb begin
    slice_a = 4'h0;
    slice_b = 4'h0;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (idx_q == IdxW'(i)) begin
        slice_a = a_q[4*i +: 4];
        slice_b = b_q[4*i +: 4];
      end
    end
  end

  // 4-bit carry-lookahead slice: every carry is a flat sum of generate/propagate products.
  always_comb begin
    slice_g    = slice_a & slice_b;
    slice_p    = slice_a ^ slice_b;
    slice_c[0] = carry_q;
    slice_c[1] = slice_g[0] | (slice_p[0] & carry_q);
    slice_c[2] = slice_g[1] | (slice_p[1] & slice_g[0]) | (slice_p[1] & slice_p[0] & carry_q);
    slice_c[3] = slice_g[2] | (slice_p[2] & slice_g[1]) | (slice_p[2] & slice_p[1] & slice_g[0])
               | (slice_p[2] & slice_p[1] & slice_p[0] & carry_q);
    slice_c[4] = slice_g[3] | (slice_p[3] & slice_g[2]) | (slice_p[3] & slice_p[2] & slice_g[1])
               | (slice_p[3] & slice_p[2] & slice_p[1] & slice_g[0])
               | (slice_p[3] & slice_p[2] & slice_p[1] & slice_p[0] & carry_q);
    slice_sum  = slice_p ^ slice_c[3:0];
  end

  // Datapath next state: latch operands on accept, fold one nibble per ADD cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
        end
      end
      StAdd: begin
        for (int i = 0; i < int'(NIBBLES); i++) begin
          if (idx_q == IdxW'(i)) begin
            sum_d[4*i +: 4] = slice_sum;
          end
        end
        carry_d = slice_c[4];
        if (last_nibble) begin
          idx_d  = '0;
          cout_d = slice_c[4];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          // Top bit of the result is bit 3 of the final slice sum.
          ovf_d  = (a_q[Width-1] == b_q[Width-1]) && (slice_sum[3] != a_q[Width-1]);
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything so an aborted operation leaves no result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4). Expected results come from
// plain (WIDTH+1)-bit arithmetic on the applied operands.
module tb_nibble_serial_adder;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .busy      (busy)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation starting at a negedge; returns at the negedge after the output handshake.
  // stall: DONE cycles with out_ready low. hold_next: present the next operands during the
  // stall. expect_now: operands were already pending, so acceptance must be immediate.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                       input int stall, input logic hold_next, input logic expect_now,
                       input logic [W-1:0] nav, input logic [W-1:0] nbv);
    logic [W:0] exp;
    int         waits;
    int         lat;
    int         low;
    exp = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    a = av;
    b = bv;
    c_in = cv;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    waits = 0;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (expect_now) chk("accept_first_idle", 64'(waits), 64'd0);
    @(posedge clk);
    #1;
    // Scramble the inputs: the adder must use its latched copy.
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    c_in = 1'($urandom);
    lat = 0;
    low = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      if (!in_ready) low++;
      lat++;
      @(negedge clk);
    end
    chk("latency", 64'(lat), 64'(N));
    chk("sum", 64'(sum), 64'(exp[W-1:0]));
    chk("c_out", 64'(c_out), 64'(exp[W]));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    chk("ovf", 64'(ovf), 64'((av[W-1] == bv[W-1]) && (exp[W-1] != av[W-1])));
`endif
    for (int i = 0; i < stall; i++) begin
      if (hold_next && i == 0) begin
        a = nav;
        b = nbv;
        c_in = 1'b0;
        in_valid = 1'b1;
      end
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_sum", 64'(sum), 64'(exp[W-1:0]));
      chk("stall_cout", 64'(c_out), 64'(exp[W]));
      if (hold_next) chk("held_off", 64'(in_ready), 64'd0);
      if (!in_ready) low++;
      @(negedge clk);
    end
    if (!in_ready) low++;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ready_low_cycles", 64'(low), 64'(N + 1 + stall));
    chk("valid_dropped", 64'(out_valid), 64'd0);
    chk("idle_ready", 64'(in_ready), 64'd1);
    chk("sum_held", 64'(sum), 64'(exp[W-1:0]));
    chk("cout_held", 64'(c_out), 64'(exp[W]));
  endtask

  initial begin
    int waits;
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_c_out", 64'(c_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors.
    do_op(16'h0000, 16'h0000, 1'b0, 0, 1'b0, 1'b0, '0, '0);
    do_op(16'h0035, 16'h0053, 1'b0, 0, 1'b0, 1'b0, '0, '0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0, '0, '0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0, 1'b0, '0, '0);
    do_op(16'hAAAA, 16'h5555, 1'b1, 0, 1'b0, 1'b0, '0, '0);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0, 1'b0, '0, '0);

    // Backpressure with the next operation already pending.
    do_op(16'h1357, 16'h2468, 1'b0, 6, 1'b1, 1'b0, 16'h0F0F, 16'h00F1);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0, 1'b1, '0, '0);

    // Reset in the middle of ADD (nibble index 2).
    a = 16'h9999;
    b = 16'h7777;
    c_in = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_add_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_add_valid", 64'(out_valid), 64'd0);
    chk("abort_add_sum", 64'(sum), 64'd0);
    chk("abort_add_cout", 64'(c_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_add_ready", 64'(in_ready), 64'd1);
    chk("abort_add_valid2", 64'(out_valid), 64'd0);
    chk("abort_add_sum2", 64'(sum), 64'd0);
    do_op(16'h1234, 16'h1111, 1'b0, 0, 1'b0, 1'b0, '0, '0);

    // Reset while the result waits in DONE.
    a = 16'h4321;
    b = 16'h1000;
    c_in = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waits = 0;
    @(negedge clk);
    while (!out_valid && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    chk("done_reached", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_done_valid", 64'(out_valid), 64'd0);
    chk("abort_done_sum", 64'(sum), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_done_ready", 64'(in_ready), 64'd1);
    chk("abort_done_busy", 64'(busy), 64'd0);

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    do_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0, '0, '0);
    do_op(16'h8000, 16'hFFFF, 1'b0, 0, 1'b0, 1'b0, '0, '0);
    do_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0, 1'b0, '0, '0);
`endif

    // Randomized operations with random backpressure.
    for (int t = 0; t < 24; t++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            1'b0, 1'b0, '0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
